cacheline_burst_adapter: RTL and testbench
==========================================

Name: cacheline_burst_adapter

Overview:
- Memory-side responder for the L1 data/instruction cache physical-memory interface.
- Accepts a whole-line read or write request from the cache and returns a one-cycle response when the transfer is done.
- Converts each line transfer into a fixed-length burst of narrow beats on the main-memory bus.
- Sits between the cache controller's pmem port and the physical memory model/arbiter.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- BURST_WIDTH, 64, memory beat width in bits. LINE_WIDTH/BURST_WIDTH = BURSTS (4). Must divide exactly.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- line_i  input  LINE_WIDTH  write data from cache; sampled when the request is accepted.
- line_o  output  LINE_WIDTH  read data to cache.
- address_i  input  ADDR_WIDTH  line address from cache.
- read_i  input  1  cache line read request; held until resp_o.
- write_i  input  1  cache line write request; held until resp_o.
- resp_o  output  1  one-cycle completion pulse to cache.
- burst_i  input  BURST_WIDTH  read beat from memory.
- burst_o  output  BURST_WIDTH  write beat to memory.
- address_o  output  ADDR_WIDTH  line-aligned burst address.
- read_o  output  1  burst read request to memory.
- write_o  output  1  burst write request to memory.
- resp_i  input  1  memory beat-valid/accept strobe.

Behaviour:
- Reset (async, rst_n=0):
  - State -> IDLE; beat counter = 0; line buffer = 0; address register = 0.
  - Outputs: line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0.
  - Reset mid-burst aborts the transfer with no resp_o. Memory-side cleanup is the memory's concern.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On a rising edge with write_i=1: latch address_i with low log2(LINE_WIDTH/8) bits forced to 0, latch line_i, go to WRITE.
  - Else with read_i=1: latch the address the same way, go to READ.
  - write_i and read_i both high: write wins (protocol violation, handled deterministically).
- READ:
  - read_o=1 and address_o = latched address, held constant for the whole state.
  - Each edge with resp_i=1 stores burst_i into line buffer slice [k*BW +: BW], where k = counter. Beat 0 is the LS bits. Counter then increments.
  - resp_i=0 cycles are stalls: no capture, no increment.
  - On the edge capturing beat BURSTS-1: counter wraps to 0, go to DONE.
- WRITE:
  - write_o=1, address_o = latched address.
  - burst_o = latched line slice [k*BW +: BW] with k = counter, valid from the first WRITE cycle.
  - Each edge with resp_i=1 advances the counter (beat accepted). After beat BURSTS-1 is accepted: counter -> 0, go to DONE.
  - resp_i=0 holds burst_o.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0. Then IDLE.
  - For a read, line_o presents the assembled line from the DONE cycle onward. It is held until the next read's DONE; writes do not disturb line_o.
  - The requester deasserts read_i/write_i before the edge ending the resp_o cycle. IDLE therefore never re-accepts a completed request.
- read_o/write_o:
  - Combinational from state only, never both high.
  - Never asserted in IDLE or DONE.
- Latency, zero-stall memory with resp_i high on every beat starting the first READ/WRITE cycle:
  - Request sampled at edge 0.
  - READ/WRITE occupies cycles 1..BURSTS.
  - resp_o in cycle BURSTS+1 (5 at defaults).
- resp_i outside READ/WRITE is ignored.
- Counter width is log2(BURSTS), wrap-around by natural overflow.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle with read_i=1 -> all outputs 0 immediately (asynchronous). Release -> IDLE, no resp_o until a new request.
2. Line read: address_i=0x0000_1234, read_i=1; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
   - address_o=0x0000_1220 throughout.
   - line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
   - resp_o is a single pulse at cycle 5.
3. Line write:
   - Stimulus: line_i = {D3,D2,D1,D0}, write_i=1, resp_i stalled low for 2 cycles between beats 1 and 2.
   - Response: burst_o sequence D0,D1,(D2 held through the stall),D2,D3; write_o high until the last beat is accepted; resp_o one cycle after.
4. Simultaneous read_i=1 and write_i=1 in IDLE -> write_o asserted, read_o never asserted, one resp_o.
5. Back-to-back: read, then write on the cycle after resp_o drops, then read.
   - Each request gets exactly one resp_o.
   - line_o is unchanged across the write.
   - The second read overwrites it with the new data.
6. Reset during WRITE after 2 beats -> write_o drops immediately, no resp_o. A following read completes normally with counter starting at beat 0.

Source files
------------

// File: rtl/cacheline_burst_adapter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_burst_adapter_if
//  Description : Cache pmem port plus main-memory burst port, bundled for the
//                cacheline burst adapter. "slave" is the adapter's view,
//                "master" is the view of the cache/memory environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cacheline_burst_adapter_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
);
  // cache side
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  // memory side
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface
`default_nettype wire

// File: rtl/cacheline_burst_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_burst_adapter
//  Description : Responds to whole-line cache reads/writes by running a fixed
//                length burst of narrow beats on the memory bus, then pulses
//                a one-cycle completion back to the cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module cacheline_burst_adapter #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  cacheline_burst_adapter_if.slave bus
);

  localparam int c_BURSTS = LINE_WIDTH / BURST_WIDTH;
  localparam int c_CNT_W  = (c_BURSTS > 1) ? $clog2(c_BURSTS) : 1;
  localparam int c_OFS_W  = $clog2(LINE_WIDTH / 8);
  localparam logic [c_CNT_W-1:0]    c_LAST_BEAT = c_CNT_W'(c_BURSTS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_OFS_MASK  = ADDR_WIDTH'((64'd1 << c_OFS_W) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                                  r_state;
  state_t                                  w_next_state;
  logic [c_CNT_W-1:0]                      r_cnt;
  logic [ADDR_WIDTH-1:0]                   r_addr;
  // Beat-indexed views of the line: element 0 is the least significant beat.
  logic [c_BURSTS-1:0][BURST_WIDTH-1:0]    r_wdata;
  logic [c_BURSTS-1:0][BURST_WIDTH-1:0]    r_rdata;
  logic [c_BURSTS-1:0][BURST_WIDTH-1:0]    r_line_out;
  logic [c_BURSTS-1:0][BURST_WIDTH-1:0]    w_rdata_next;
  logic [ADDR_WIDTH-1:0]                   w_addr_aligned;
  logic                                    w_last_beat;
  logic                                    w_read_o;
  logic                                    w_write_o;
  logic                                    w_resp_o;
  logic [BURST_WIDTH-1:0]                  w_burst_o;

  assign w_addr_aligned = bus.address_i & ~c_OFS_MASK;
  assign w_last_beat    = (r_cnt == c_LAST_BEAT);

  // Read assembly: the beat on burst_i dropped into the slot selected by the counter.
  always_comb begin
    w_rdata_next        = r_rdata;
    w_rdata_next[r_cnt] = bus.burst_i;
  end

  // State register; an asynchronous reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and strobe decode; memory strobes depend on state alone.
  always_comb begin
    w_next_state = r_state;
    w_read_o     = 1'b0;
    w_write_o    = 1'b0;
    w_resp_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Write takes precedence if the cache illegally raises both.
        if (bus.write_i) begin
          w_next_state = ST_WRITE;
        end else if (bus.read_i) begin
          w_next_state = ST_READ;
        end
      end
      ST_READ: begin
        w_read_o = 1'b1;
        if (bus.resp_i && w_last_beat) begin
          w_next_state = ST_DONE;
        end
      end
      ST_WRITE: begin
        w_write_o = 1'b1;
        if (bus.resp_i && w_last_beat) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_resp_o     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: request latch, beat counter, read capture and line_o update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_line_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.write_i) begin
            r_addr  <= w_addr_aligned;
            r_wdata <= bus.line_i;
          end else if (bus.read_i) begin
            r_addr <= w_addr_aligned;
          end
        end
        ST_READ: begin
          if (bus.resp_i) begin
            r_rdata <= w_rdata_next;
            if (w_last_beat) begin
              r_cnt      <= '0;
              // line_o only changes once the whole line has arrived.
              r_line_out <= w_rdata_next;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (bus.resp_i) begin
            if (w_last_beat) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outgoing write beat is held steady while memory stalls.
  assign w_burst_o = (r_state == ST_WRITE) ? r_wdata[r_cnt] : '0;

  assign bus.read_o    = w_read_o;
  assign bus.write_o   = w_write_o;
  assign bus.resp_o    = w_resp_o;
  assign bus.burst_o   = w_burst_o;
  assign bus.address_o = r_addr;
  assign bus.line_o    = r_line_out;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_burst_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cacheline_burst_adapter
//  Description : Scoreboard bench for cacheline_burst_adapter. A requester
//                issues line transfers, a memory responder serves beats and
//                checks write data, and a monitor checks each resp_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_burst_adapter;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NB = LW / BW;

  typedef struct {
    bit          is_write;
    logic [LW-1:0] line;
  } exp_t;

  logic clk;
  logic rst_n;

  cacheline_burst_adapter_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  cacheline_burst_adapter #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];
  logic [BW-1:0] rd_beat_q[$];
  logic [BW-1:0] wr_beat_q[$];
  bit            pat_q[$];
  logic [BW-1:0] rd_beats[NB];
  logic [AW-1:0] exp_addr = '0;
  bit            cur_is_write = 1'b0;
  int            stall_pct = 0;
  logic [LW-1:0] last_line = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Issue a request at a negedge and queue what the line-level model expects.
  task automatic start_req(input bit wr, input bit rd, input logic [AW-1:0] addr,
                           input logic [LW-1:0] line);
    exp_t e;
    bus.address_i = addr;
    bus.line_i    = line;
    bus.write_i   = wr;
    bus.read_i    = rd;
    exp_addr      = {addr[AW-1:5], 5'b0};
    cur_is_write  = wr;
    e.is_write    = wr;
    e.line        = '0;
    if (wr) begin
      for (int k = 0; k < NB; k++) wr_beat_q.push_back(line[k*BW +: BW]);
      e.line = line;
    end else begin
      for (int k = 0; k < NB; k++) begin
        rd_beat_q.push_back(rd_beats[k]);
        e.line[k*BW +: BW] = rd_beats[k];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus.resp_o === 1'b1) break;
      if (lat > 200) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout waited=%0d cycles required=resp_o", lat);
        break;
      end
    end
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
  endtask

  task automatic do_req(input bit wr, input bit rd, input logic [AW-1:0] addr,
                        input logic [LW-1:0] line, output int lat);
    start_req(wr, rd, addr, line);
    wait_resp(lat);
  endtask

  task automatic rand_beats();
    for (int k = 0; k < NB; k++) rd_beats[k] = {$urandom, $urandom};
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW/32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // An aborted transfer leaves nothing outstanding; line_o is cleared by reset.
  task automatic flush_model();
    exp_q.delete();
    rd_beat_q.delete();
    wr_beat_q.delete();
    pat_q.delete();
    last_line   = '0;
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_o"},    LW'(bus.read_o),    '0);
    chk({tag, "_write_o"},   LW'(bus.write_o),   '0);
    chk({tag, "_resp_o"},    LW'(bus.resp_o),    '0);
    chk({tag, "_line_o"},    bus.line_o,         '0);
    chk({tag, "_burst_o"},   LW'(bus.burst_o),   '0);
    chk({tag, "_address_o"}, LW'(bus.address_o), '0);
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_no_resp"}, LW'(bus.resp_o), '0);
    end
  endtask

  // Memory responder: serves read beats, checks write beats and the address.
  initial begin
    bit r;
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    forever begin
      @(negedge clk);
      chk("strobe_exclusive", LW'(bus.read_o & bus.write_o), '0);
      if (bus.read_o === 1'b1 || bus.write_o === 1'b1) begin
        chk("address_o", LW'(bus.address_o), LW'(exp_addr));
        chk("op_kind_write_o", LW'(bus.write_o), LW'(cur_is_write));
        if (pat_q.size() > 0) r = pat_q.pop_front();
        else                  r = ($urandom_range(99) >= stall_pct);
        bus.resp_i = r;
        if (bus.read_o === 1'b1) begin
          if (!r) begin
            bus.burst_i = {$urandom, $urandom};
          end else if (rd_beat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_read_beat actual=read_o_high required=no_more_beats");
          end else begin
            bus.burst_i = rd_beat_q.pop_front();
          end
        end else begin
          if (wr_beat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_write_beat actual=write_o_high required=no_more_beats");
          end else begin
            chk("burst_o", LW'(bus.burst_o), LW'(wr_beat_q[0]));
            if (r) void'(wr_beat_q.pop_front());
          end
        end
      end else begin
        // Strobes outside a burst must be ignored by the adapter.
        bus.resp_i  = 1'($urandom_range(1));
        bus.burst_i = {$urandom, $urandom};
      end
    end
  end

  // Completion monitor: one pulse per request, line_o per the line-level rules.
  initial begin
    bit   prev_resp;
    exp_t e;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.resp_o === 1'b1) begin
        chk("resp_single_cycle", LW'(prev_resp), '0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=resp_o_high required=no_request_pending");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_write) begin
            chk("line_o_after_read", bus.line_o, e.line);
            last_line = e.line;
          end else begin
            chk("line_o_kept_on_write", bus.line_o, last_line);
            chk("write_beats_drained", LW'(wr_beat_q.size()), '0);
          end
        end
      end
      prev_resp = (bus.resp_o === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            lat;
    int            sel;
    logic [LW-1:0] d;
    rst_n         = 1'b0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    quiet_cycles("post_reset", 2);

    // Directed line read, zero-stall memory.
    stall_pct   = 0;
    rd_beats[0] = {16{4'h1}};
    rd_beats[1] = {16{4'h2}};
    rd_beats[2] = {16{4'h3}};
    rd_beats[3] = {16{4'h4}};
    do_req(1'b0, 1'b1, 32'h0000_1234, '0, lat);
    chk("read_latency", LW'(lat), LW'(5));
    chk("read_line_o", bus.line_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    @(negedge clk);

    // Asynchronous reset in the middle of a read.
    rand_beats();
    start_req(1'b0, 1'b1, 32'hABCD_0047, '0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset_mid_read");
    flush_model();
    @(negedge clk);
    rst_n = 1'b1;
    quiet_cycles("after_read_abort", 4);

    // Directed write with a two-cycle stall between beats 1 and 2.
    d = rand_line();
    pat_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_req(1'b1, 1'b0, 32'h8000_00FF, d, lat);
    chk("write_latency_with_stall", LW'(lat), LW'(7));
    @(negedge clk);

    // Read and write raised together: the write must win.
    do_req(1'b1, 1'b1, 32'h0000_2020, rand_line(), lat);
    chk("both_latency", LW'(lat), LW'(5));
    @(negedge clk);

    // Back-to-back read, write, read.
    stall_pct = 20;
    rand_beats();
    do_req(1'b0, 1'b1, $urandom, '0, lat);
    @(negedge clk);
    do_req(1'b1, 1'b0, $urandom, rand_line(), lat);
    @(negedge clk);
    rand_beats();
    do_req(1'b0, 1'b1, $urandom, '0, lat);
    @(negedge clk);

    // Reset during a write after two beats are accepted.
    stall_pct = 0;
    start_req(1'b1, 1'b0, 32'h1357_9BDF, rand_line());
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_write_write_o", LW'(bus.write_o), '0);
    chk("reset_mid_write_resp_o", LW'(bus.resp_o), '0);
    flush_model();
    @(negedge clk);
    rst_n = 1'b1;
    quiet_cycles("after_write_abort", 3);
    rand_beats();
    do_req(1'b0, 1'b1, 32'h0000_4444, '0, lat);
    chk("read_after_abort_latency", LW'(lat), LW'(5));
    @(negedge clk);

    // Randomized traffic with memory stalls.
    stall_pct = 35;
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(9);
      if (sel == 0) begin
        do_req(1'b1, 1'b1, $urandom, rand_line(), lat);
      end else if (sel < 5) begin
        do_req(1'b1, 1'b0, $urandom, rand_line(), lat);
      end else begin
        rand_beats();
        do_req(1'b0, 1'b1, $urandom, '0, lat);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    chk("scoreboard_empty", LW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
